// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory bus signals shared around the memory arbiter
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          stall_mem;
  logic          mem_err;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall_mem, mem_err
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall_mem, mem_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory between instruction fetch and data ports
module mem_arbiter #(
  parameter int MAX_DM_BURST = 4,
  parameter int TIMEOUT      = 255
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int BW = $clog2(MAX_DM_BURST + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_t;
  state_t        state, state_nxt;
  logic [BW-1:0] burst_cnt;
  logic [WW-1:0] wdog;
  logic          gnt_dm, acc, dm_win, grant, tmo, done;
  // Data wins unless fetch has already waited through a full data burst
  assign acc           = state == IF_ACC || state == DM_ACC;
  assign dm_win        = bus.dm_req && (!bus.if_req || burst_cnt < BW'(MAX_DM_BURST));
  assign grant         = state == IDLE && (bus.dm_req || bus.if_req);
  assign tmo           = !bus.mem_ack && wdog == WW'(TIMEOUT - 1);
  assign done          = acc && (bus.mem_ack || tmo);
  assign bus.mem_req   = acc;
  assign bus.if_ready  = state == RESP && !gnt_dm;
  assign bus.dm_ready  = state == RESP && gnt_dm;
  assign bus.stall_mem = (bus.if_req && !bus.if_ready) || (bus.dm_req && !bus.dm_ready);
  // State register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  // Next state: grant from IDLE, close the access on ack or watchdog, one RESP cycle
  always_comb begin
    state_nxt = state;
    if (grant) state_nxt = dm_win ? DM_ACC : IF_ACC;
    else if (done) state_nxt = RESP;
    else if (state == RESP) state_nxt = IDLE;
  end
  // Grant capture, burst fairness counter, watchdog and response data
  always_ff @(posedge clk)
    if (reset) begin
      burst_cnt     <= '0;
      wdog          <= '0;
      gnt_dm        <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
      bus.mem_err   <= 1'b0;
    end else begin
      wdog <= acc ? wdog + WW'(1) : '0;
      if (grant) begin
        gnt_dm        <= dm_win;
        bus.mem_we    <= dm_win && bus.dm_we;
        bus.mem_addr  <= dm_win ? bus.dm_addr : bus.if_addr;
        bus.mem_wdata <= dm_win ? bus.dm_wdata : '0;
        burst_cnt     <= (dm_win && bus.if_req) ? burst_cnt + BW'(burst_cnt != BW'(MAX_DM_BURST)) : '0;
      end
      if (done) begin
        if (state == DM_ACC) bus.dm_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
        else bus.if_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
        bus.mem_err <= bus.mem_err || !bus.mem_ack;
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for the fetch/data memory arbiter
module tb_mem_arbiter;
  localparam int MAXB = 4;
  localparam int TMO  = 255;
  logic clk, reset;
  mem_arbiter_if bus ();
  mem_arbiter #(.MAX_DM_BURST(MAXB), .TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int fails  = 0;
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  bit          gnt_log[$];
  logic [31:0] cur_if_addr, cur_dm_addr, cur_dm_wdata;
  logic        cur_dm_we;
  bit          mem_on, late_req, late_done;
  int          lat_fixed, late_n, rsp_cnt, rsp_lat;

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory model: acks after a chosen latency with data derived from the address
  initial begin
    bus.mem_ack = 0;
    bus.mem_rdata = 0;
    late_done = 0;
    late_n = 0;
    rsp_cnt = 0;
    rsp_lat = 1;
    forever begin
      @(negedge clk);
      bus.mem_ack = 0;
      if (late_req && !late_done) begin
        late_n++;
        if (late_n == 2) begin
          bus.mem_ack = 1;
          bus.mem_rdata = 32'hDEAD_BEEF;
          late_done = 1;
        end
      end else if (bus.mem_req && mem_on) begin
        if (rsp_cnt == 0) rsp_lat = lat_fixed != 0 ? lat_fixed : int'($urandom_range(1, 4));
        rsp_cnt++;
        if (rsp_cnt >= rsp_lat) begin
          bus.mem_ack = 1;
          bus.mem_rdata = mem_f(bus.mem_addr);
          rsp_cnt = 0;
        end
      end else rsp_cnt = 0;
    end
  end

  // Monitor: completions against the scoreboard, grants against the arbitration rules
  initial begin
    logic        prev_req, g_if, g_dm, rst_s, exp_dm, act_dm;
    logic [31:0] start_addr;
    int          streak;
    prev_req = 0;
    streak = 0;
    start_addr = 0;
    forever begin
      @(posedge clk);
      g_if = bus.if_req;
      g_dm = bus.dm_req;
      rst_s = reset;
      #1;
      if (rst_s) begin
        streak = 0;
        prev_req = 0;
      end else begin
        if (bus.if_ready) begin
          if (if_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL if_ready_unexpected: got if_ready=1 rdata=%h want no pending fetch", bus.if_rdata);
          end else chk("if_rdata", bus.if_rdata, if_q.pop_front());
        end
        if (bus.dm_ready) begin
          if (dm_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL dm_ready_unexpected: got dm_ready=1 rdata=%h want no pending data access", bus.dm_rdata);
          end else chk("dm_rdata", bus.dm_rdata, dm_q.pop_front());
        end
        if (bus.mem_req && !prev_req) begin
          if (!g_if && !g_dm) chk("grant_spurious", bus.mem_req, 0);
          else begin
            exp_dm = g_dm && (!g_if || streak < MAXB);
            act_dm = g_dm && bus.mem_addr == cur_dm_addr && !(g_if && cur_if_addr == cur_dm_addr);
            chk("grant_port", act_dm, exp_dm);
            chk("grant_addr", bus.mem_addr, exp_dm ? cur_dm_addr : cur_if_addr);
            chk("grant_we", bus.mem_we, exp_dm & cur_dm_we);
            if (exp_dm && cur_dm_we) chk("grant_wdata", bus.mem_wdata, cur_dm_wdata);
            streak = (exp_dm && g_if) ? streak + 1 : 0;
            gnt_log.push_back(act_dm);
          end
          start_addr = bus.mem_addr;
        end else if (bus.mem_req) chk("mem_addr_hold", bus.mem_addr, start_addr);
        prev_req = bus.mem_req;
      end
    end
  end

  task automatic run_if(input int n, input int gmax);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      int w;
      a = {16'h0, 14'($urandom), 2'b00};
      cur_if_addr = a;
      bus.if_addr = a;
      if_q.push_back(mem_f(a));
      bus.if_req = 1;
      w = 0;
      do begin @(negedge clk); w++; end while (!bus.if_ready && w < 1000);
      if (!bus.if_ready) begin
        checks++; fails++;
        $display("FAIL if_txn_timeout: got no if_ready in %0d cycles want a completion", w);
      end
      bus.if_req = 0;
      repeat ($urandom_range(0, gmax)) @(negedge clk);
    end
  endtask

  task automatic run_dm(input int n, input int gmax);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, d;
      logic we;
      int w;
      a = {1'b1, 15'h0, 14'($urandom), 2'b00};
      d = $urandom;
      we = 1'($urandom);
      cur_dm_addr = a;
      cur_dm_we = we;
      cur_dm_wdata = d;
      bus.dm_addr = a;
      bus.dm_we = we;
      bus.dm_wdata = d;
      dm_q.push_back(mem_f(a));
      bus.dm_req = 1;
      w = 0;
      do begin @(negedge clk); w++; end while (!bus.dm_ready && w < 1000);
      if (!bus.dm_ready) begin
        checks++; fails++;
        $display("FAIL dm_txn_timeout: got no dm_ready in %0d cycles want a completion", w);
      end
      bus.dm_req = 0;
      repeat ($urandom_range(0, gmax)) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end of test want completion within 1ms");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int pulses, stall_lo, bad, base, n, cyc;
    logic [5:0] want;
    reset = 1;
    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    cur_if_addr = 0; cur_dm_addr = 0; cur_dm_we = 0; cur_dm_wdata = 0;
    mem_on = 1; lat_fixed = 1; late_req = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_dm_ready", bus.dm_ready, 0);
    chk("rst_mem_err", bus.mem_err, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    chk("rst_stall", bus.stall_mem, 0);
    reset = 0;
    @(negedge clk);
    // Fetch alone with ack in the first access cycle
    bus.if_addr = 32'h8; cur_if_addr = 32'h8; if_q.push_back(mem_f(32'h8)); bus.if_req = 1;
    #1 chk("t1_stall_wait", bus.stall_mem, 1);
    @(negedge clk);
    chk("t1_mem_req", bus.mem_req, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h8);
    chk("t1_mem_we", bus.mem_we, 0);
    chk("t1_ready_early", bus.if_ready, 0);
    @(negedge clk);
    chk("t1_if_ready", bus.if_ready, 1);
    chk("t1_if_rdata", bus.if_rdata, mem_f(32'h8));
    chk("t1_stall_resp", bus.stall_mem, 0);
    bus.if_req = 0;
    @(negedge clk);
    chk("t1_ready_pulse", bus.if_ready, 0);
    chk("t1_mem_req_idle", bus.mem_req, 0);
    // Store held on the memory bus for three cycles
    lat_fixed = 3;
    cur_dm_addr = 32'h64; cur_dm_we = 1; cur_dm_wdata = 32'h7;
    bus.dm_addr = 32'h64; bus.dm_we = 1; bus.dm_wdata = 32'h7;
    dm_q.push_back(mem_f(32'h64)); bus.dm_req = 1;
    pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      pulses += int'(bus.dm_ready);
      if (c <= 3) begin
        chk("t2_mem_req", bus.mem_req, 1);
        chk("t2_mem_addr", bus.mem_addr, 32'h64);
        chk("t2_mem_we", bus.mem_we, 1);
        chk("t2_mem_wdata", bus.mem_wdata, 32'h7);
      end
      if (c == 4) chk("t2_dm_ready", bus.dm_ready, 1);
      if (bus.dm_ready) bus.dm_req = 0;
    end
    bus.dm_req = 0;
    chk("t2_ready_pulses", pulses, 1);
    // Simultaneous requests: data first, fetch right after the data response
    lat_fixed = 1;
    bus.if_addr = 32'h10; cur_if_addr = 32'h10;
    bus.dm_addr = 32'h80; bus.dm_we = 0; bus.dm_wdata = 0;
    cur_dm_addr = 32'h80; cur_dm_we = 0; cur_dm_wdata = 0;
    if_q.push_back(mem_f(32'h10)); dm_q.push_back(mem_f(32'h80));
    bus.if_req = 1; bus.dm_req = 1;
    stall_lo = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) stall_lo += int'(!bus.stall_mem);
      if (c == 1) chk("t3_dm_first", bus.mem_addr, 32'h80);
      if (c == 2) begin chk("t3_dm_ready", bus.dm_ready, 1); bus.dm_req = 0; end
      if (c == 4) begin
        chk("t3_if_mem_req", bus.mem_req, 1);
        chk("t3_if_addr", bus.mem_addr, 32'h10);
        chk("t3_if_we", bus.mem_we, 0);
      end
      if (c == 5) begin chk("t3_if_ready", bus.if_ready, 1); bus.if_req = 0; end
    end
    bus.dm_req = 0; bus.if_req = 0;
    chk("t3_stall_hold", stall_lo, 0);
    @(negedge clk);
    // Both ports saturated: data burst is capped before fetch gets a turn
    base = gnt_log.size();
    fork
      run_if(2, 0);
      run_dm(6, 0);
    join
    chk("t4_grant_count", gnt_log.size() - base, 8);
    want = 6'b101111;
    if (gnt_log.size() >= base + 6)
      for (int i = 0; i < 6; i++) chk("t4_grant_order", gnt_log[base + i], want[i]);
    // Randomised traffic with random memory latency
    lat_fixed = 0;
    fork
      run_if(40, 3);
      run_dm(40, 3);
    join
    @(negedge clk);
    chk("rand_mem_err", bus.mem_err, 0);
    chk("rand_queues_drained", if_q.size() + dm_q.size(), 0);
    // Memory never acks: watchdog closes the access with zero data
    mem_on = 0;
    cur_dm_addr = 32'h8000_0100; cur_dm_we = 0; cur_dm_wdata = 0;
    bus.dm_addr = 32'h8000_0100; bus.dm_we = 0; bus.dm_wdata = 0;
    dm_q.push_back(32'h0); bus.dm_req = 1;
    n = 0; cyc = 0;
    do begin @(negedge clk); cyc++; n += int'(bus.mem_req); end while (!bus.dm_ready && cyc < 400);
    chk("t5_acc_cycles", n, TMO);
    chk("t5_dm_ready", bus.dm_ready, 1);
    chk("t5_mem_err", bus.mem_err, 1);
    chk("t5_stall_resp", bus.stall_mem, 0);
    bus.dm_req = 0;
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", bus.mem_err, 1);
    // Reset in the middle of a data access, ack arriving afterwards
    cur_dm_addr = 32'h8000_0200; cur_dm_we = 1; cur_dm_wdata = 32'h1234_5678;
    bus.dm_addr = 32'h8000_0200; bus.dm_we = 1; bus.dm_wdata = 32'h1234_5678;
    bus.dm_req = 1;
    @(negedge clk);
    chk("t6_mem_req", bus.mem_req, 1);
    @(negedge clk);
    reset = 1; bus.dm_req = 0; late_req = 1;
    @(negedge clk);
    chk("t6_mem_req_reset", bus.mem_req, 0);
    chk("t6_err_cleared", bus.mem_err, 0);
    reset = 0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      bad += int'(bus.dm_ready | bus.mem_req);
    end
    chk("t6_no_response", bad, 0);
    chk("t6_err_after", bus.mem_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
